enigma_step_ctrl: RTL

//  Character sequencer on the controlling side of the rotor interface: drives rotor enable/load_config/init_pos
//  and consumes each rotor's notch_pulse. Per accepted character: steps rotors (odometer carry),

---
 rtl/enigma_step_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/enigma_step_ctrl.sv
// Character sequencer driving a 3-rotor chain: odometer stepping, path settle/sample, stream handshake.
// Optional feature macro DOUBLE_STEP_EN: middle rotor self-steps when its shadow position is NOTCH_POS.
module enigma_step_ctrl #(
    parameter int unsigned ALPHA         = 26,
    parameter int unsigned NOTCH_POS     = 16,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [14:0] cfg_pos_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [4:0]  in_char_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [4:0]  out_char_o,
    output logic        rot_load_o,
    output logic [14:0] rot_init_pos_o,
    output logic [2:0]  rot_en_o,
    input  logic [2:0]  notch_in_i,
    output logic [4:0]  path_char_out_o,
    input  logic [4:0]  path_char_ret_i
);

    localparam logic [4:0] AlphaC     = 5'(ALPHA);
    localparam logic [4:0] AlphaLast  = 5'(ALPHA - 1);
    localparam logic [4:0] NotchC     = 5'(NOTCH_POS);
    localparam logic [2:0] SettleLast = 3'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStep0,
        StStep1,
        StStep2,
        StSettle,
        StOut
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  char_q, char_d;
    logic [4:0]  out_char_q, out_char_d;
    logic [14:0] init_pos_q, init_pos_d;
    logic [4:0]  pos1_q, pos1_d;
    logic [2:0]  settle_cnt_q, settle_cnt_d;

    logic [2:0]  rot_en;
    logic        rot_load;
    logic        out_valid;
    logic        cfg_ready;
    logic        in_ready;
    logic        pos1_at_notch;
    logic        self_step;

    assign pos1_at_notch = (pos1_q == NotchC);

`ifdef DOUBLE_STEP_EN
    assign self_step = pos1_at_notch;
`else
    // Shadow position is still tracked so the feature can be enabled without other changes.
    assign self_step = 1'b0;
    logic unused_pos1_at_notch;
    assign unused_pos1_at_notch = pos1_at_notch;
`endif

    // The last rotor's carry has nowhere to go.
    logic unused_notch2;
    assign unused_notch2 = notch_in_i[2];

    always_comb begin
        state_d      = state_q;
        char_d       = char_q;
        out_char_d   = out_char_q;
        init_pos_d   = init_pos_q;
        pos1_d       = pos1_q;
        settle_cnt_d = settle_cnt_q;
        rot_en       = 3'b000;
        rot_load     = 1'b0;
        out_valid    = 1'b0;
        cfg_ready    = 1'b0;
        in_ready     = 1'b0;

        unique case (state_q)
            StIdle: begin
                cfg_ready = 1'b1;
                in_ready  = ~cfg_valid_i;
                if (cfg_valid_i) begin
                    init_pos_d = cfg_pos_i;
                    pos1_d     = cfg_pos_i[9:5];
                    state_d    = StLoad;
                end else if (in_valid_i) begin
                    if (in_char_i < AlphaC) begin
                        char_d  = in_char_i;
                        state_d = StStep0;
                    end else begin
                        out_char_d = in_char_i;
                        state_d    = StOut;
                    end
                end
            end
            StLoad: begin
                rot_load = 1'b1;
                state_d  = StIdle;
            end
            StStep0: begin
                rot_en  = 3'b001;
                state_d = StStep1;
            end
            StStep1: begin
                rot_en[1] = notch_in_i[0] | self_step;
                state_d   = StStep2;
            end
            StStep2: begin
                rot_en[2]    = notch_in_i[1];
                settle_cnt_d = 3'd0;
                state_d      = StSettle;
            end
            StSettle: begin
                if (settle_cnt_q == SettleLast) begin
                    out_char_d = path_char_ret_i;
                    state_d    = StOut;
                end else begin
                    settle_cnt_d = settle_cnt_q + 3'd1;
                end
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (rot_en[1]) begin
            pos1_d = (pos1_q == AlphaLast) ? 5'd0 : pos1_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            char_q       <= 5'd0;
            out_char_q   <= 5'd0;
            init_pos_q   <= 15'd0;
            pos1_q       <= 5'd0;
            settle_cnt_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            char_q       <= char_d;
            out_char_q   <= out_char_d;
            init_pos_q   <= init_pos_d;
            pos1_q       <= pos1_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign cfg_ready_o     = cfg_ready;
    assign in_ready_o      = in_ready;
    assign out_valid_o     = out_valid;
    assign out_char_o      = out_char_q;
    assign rot_load_o      = rot_load;
    assign rot_init_pos_o  = init_pos_q;
    assign rot_en_o        = rot_en;
    // char_q only loads for in-alphabet characters, so pass-through never disturbs the path.
    assign path_char_out_o = char_q;

    a_rot_en_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(rot_en));
    a_out_hold: assert property (@(posedge clk_i) disable iff (reset_i)
        out_valid && !out_ready_i |=> out_valid && $stable(out_char_q));

endmodule
